// File: rtl/led_blink_1hz.sv
// Free-running LED blinker: led inverts once every CLK_FREQ rising clock edges.
// Synchronous active-high reset clears both the cycle counter and the LED.
module led_blink_1hz #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic led
);

    localparam int CntW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(CLK_FREQ - 1);

    if (CLK_FREQ < 1) begin : g_bad_clk_freq
        $error("led_blink_1hz: CLK_FREQ must be at least 1");
    end

    logic [CntW-1:0] r_cnt;
    logic            r_led;

    // Wrap and toggle share one edge, so the toggle period is exactly CLK_FREQ cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (r_cnt == MaxCnt) begin
            r_cnt <= '0;
            r_led <= ~r_led;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_led_blink_1hz.sv
// Scoreboard bench for led_blink_1hz: four divisors share one clock and reset.
// Expected LED levels come from counting low-reset edges since the last reset.
module tb_led_blink_1hz;

    localparam int NumDut = 4;

    typedef struct packed {
        logic [NumDut-1:0] led;
    } exp_t;

    logic clk;
    logic reset;
    logic led_10;
    logic led_1;
    logic led_7;
    logic led_def;

    exp_t exp_q[$];
    int   k[NumDut];
    int   div[NumDut];
    int   total;
    int   bad;

    led_blink_1hz #(.CLK_FREQ(10)) u_dut_10 (.clk(clk), .reset(reset), .led(led_10));
    led_blink_1hz #(.CLK_FREQ(1))  u_dut_1  (.clk(clk), .reset(reset), .led(led_1));
    led_blink_1hz #(.CLK_FREQ(7))  u_dut_7  (.clk(clk), .reset(reset), .led(led_7));
    led_blink_1hz                  u_dut_def (.clk(clk), .reset(reset), .led(led_def));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: after k low-reset edges the LED has toggled floor(k/N) times.
    function automatic logic model_led(input int kk, input int n);
        return ((kk / n) % 2) == 1;
    endfunction

    task automatic step(input logic rst);
        exp_t e;
        reset = rst;
        @(posedge clk);
        for (int i = 0; i < NumDut; i++) begin
            if (rst) k[i] = 0;
            else k[i] = k[i] + 1;
            e.led[i] = rst ? 1'b0 : model_led(k[i], div[i]);
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
        end
    endtask

    // Monitor: every registered output is compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("led_div10", led_10, e.led[0]);
            check("led_div1", led_1, e.led[1]);
            check("led_div7", led_7, e.led[2]);
            check("led_default", led_def, e.led[3]);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        div[0] = 10;
        div[1] = 1;
        div[2] = 7;
        div[3] = 100_000_000;
        for (int i = 0; i < NumDut; i++) k[i] = 0;
        reset = 1'b1;

        // Reset hold, then a long free run covering several toggle periods.
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 60; i++) step(1'b0);
        // Advance to counter=6 with led=1 on the divide-by-10 instance, then reset once.
        for (int i = 0; i < 16; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 25; i++) step(1'b0);

        // Random reset pulses of 1-3 cycles, including mid-interval.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                int len;
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) step(1'b1);
            end else begin
                step(1'b0);
            end
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
